imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Arbiter and sequencer for the single-port instruction memory. It shares the memory between the core's fetch stage and the program loader (boot/debug write path). It converts byte addresses to word indices, substitutes NOP bubbles, and bounds loader bursts so fetch is never starved indefinitely. It sits between the IF stage and the I-memory array, and the memory sees only this block's port.

## Interface
- `DEPTH`, 512: memory words; index = (addr >> 2) mod DEPTH.
- `IDX_W`, 9: width of `mem_idx` (log2 DEPTH).
- `BURST_MAX`, 8: max consecutive loader grants while `fetch_req` is pending; range 1..255.
- `NOP_WORD`, 32'h00000013: instruction returned for bubbles and at reset.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `fetch_req` in 1: fetch request this cycle.
- `fetch_addr` in 32: byte address of fetch.
- `fetch_nop` in 1: bubble request; returns `NOP_WORD` with no memory access.
- `fetch_gnt` out 1: fetch accepted this cycle (combinational).
- `fetch_valid` out 1: `fetch_instr` valid this cycle.
- `fetch_instr` out 32: fetched instruction.
- `fetch_nop_out` out 1: bubble flag aligned with `fetch_valid`.
- `ld_req` in 1: loader write request.
- `ld_addr` in 32: loader byte address.
- `ld_wdata` in 32: loader write data.
- `ld_gnt` out 1: loader write accepted this cycle (combinational).
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_idx` out IDX_W: memory word index.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid the cycle after a read strobe (synchronous read).
- `misalign` out 1: sticky flag, set by any granted access with addr[1:0] != 0.

## Operation
- State: `owner` ∈ {IDLE, FETCH, LOAD} (last-cycle grant), `burst_cnt` [7:0], `resp_pend`, `resp_nop`, `instr_hold` [31:0].
- Grant rule, evaluated each cycle:
  - `ld_req` && (!`fetch_req` || `burst_cnt` < BURST_MAX) → loader is granted.
  - Otherwise, `fetch_req` → fetch is granted.
  - At most one grant per cycle.
- Fetch grant, `fetch_nop`=1: `mem_en`=0. Next cycle `fetch_valid`=1, `fetch_instr`=NOP_WORD, `fetch_nop_out`=1.
- Fetch grant, `fetch_nop`=0: `mem_en`=1, `mem_we`=0, `mem_idx`=fetch_addr[IDX_W+1:2]. Next cycle `fetch_valid`=1, `fetch_instr`=`mem_rdata`, `fetch_nop_out`=0.
- Loader grant: `mem_en`=1, `mem_we`=1, `mem_idx`=ld_addr[IDX_W+1:2], `mem_wdata`=`ld_wdata`. No fetch response.
- `burst_cnt`:
  - Increments (saturating at 255) on each loader grant while `fetch_req`=1.
  - Clears on any fetch grant or any cycle with `ld_req`=0.
- `instr_hold` captures `fetch_instr` whenever `fetch_valid`=1. When `fetch_valid`=0, `fetch_instr` = `instr_hold`. Stalled IF sees a stable word.
- Address bits above IDX_W+1 are ignored (wrap). Misaligned accesses still proceed using the truncated index, and `misalign` is set.
- No grant: `mem_en`=0, `mem_we`=0, `owner` = IDLE.

## Timing
- Grants and memory strobes are combinational from inputs and registered state. No cycle of grant latency.
- Read latency: fetch granted in cycle N gives `fetch_valid` in cycle N+1. Back-to-back fetches sustain 1 instruction/cycle.
- The loader can write in cycle N while the fetch response from N-1 is returned. The read data path is not disturbed by a write.
- Same-index write in N after fetch read in N-1: the fetch returns the old word.
- Reset (`rst`=0 at edge):
  - Registered state: `owner`=IDLE, `burst_cnt`=0, `resp_pend`=0, `instr_hold`=NOP_WORD, `misalign`=0.
  - Outputs while `rst`=0: `fetch_valid`=0, `fetch_nop_out`=0, `fetch_instr`=NOP_WORD, `fetch_gnt`=`ld_gnt`=`mem_en`=`mem_we`=0.
- Reset mid-access: a pending fetch response is discarded, so no `fetch_valid` follows reset. A loader write in the reset cycle is not performed.
- Worst-case fetch wait with continuous `ld_req`: BURST_MAX cycles.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `fetch_req`=`ld_req`=1 → all grants 0, `mem_en`=0, `fetch_instr`=0x00000013, `fetch_valid`=0.
- Streaming fetch: memory preloaded with word k = 0x1000_0000+k. Fetch addrs 0,4,8,12 in consecutive cycles → `fetch_valid`=1 for 4 cycles starting one cycle later, with data 0x10000000..0x10000003.
- Bubble: `fetch_nop`=1 at addr 0x40 → `mem_en`=0, next cycle `fetch_instr`=0x00000013, `fetch_nop_out`=1.
- Starvation bound: `ld_req` and `fetch_req` held high, BURST_MAX=8 → exactly 8 `ld_gnt` cycles, then 1 `fetch_gnt`, then the pattern repeats.
- Write-then-read: loader writes 0xDEADBEEF to 0x7FC, then fetch 0x7FC → `mem_idx`=511 and `fetch_instr`=0xDEADBEEF. Fetch 0x800 → `mem_idx`=0 (wrap).
- Misalign/stall: fetch 0x06 → `misalign`=1 and stays 1. Next cycle `fetch_req`=0 → `fetch_valid`=0 and `fetch_instr` holds the previous word.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Bundles the fetch, loader and memory-side signals of the I-memory arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment that drives it (the IF stage, the loader and the memory array).
interface imem_port_arbiter_if #(
  parameter int IDX_W = 9
);
  // Fetch side
  logic             fetch_req;
  logic [31:0]      fetch_addr;
  logic             fetch_nop;
  logic             fetch_gnt;
  logic             fetch_valid;
  logic [31:0]      fetch_instr;
  logic             fetch_nop_out;
  // Loader side
  logic             ld_req;
  logic [31:0]      ld_addr;
  logic [31:0]      ld_wdata;
  logic             ld_gnt;
  // Memory side
  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  // Status
  logic             misalign;

  modport slave (
    input  fetch_req, fetch_addr, fetch_nop, ld_req, ld_addr, ld_wdata, mem_rdata,
    output fetch_gnt, fetch_valid, fetch_instr, fetch_nop_out, ld_gnt,
           mem_en, mem_we, mem_idx, mem_wdata, misalign
  );

  modport master (
    output fetch_req, fetch_addr, fetch_nop, ld_req, ld_addr, ld_wdata, mem_rdata,
    input  fetch_gnt, fetch_valid, fetch_instr, fetch_nop_out, ld_gnt,
           mem_en, mem_we, mem_idx, mem_wdata, misalign
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between the fetch stage and the
// program loader. The loader wins arbitration, but only for BURST_MAX
// consecutive grants while a fetch is waiting. Fetch reads return data one
// cycle after the grant. Bubbles return NOP_WORD without touching the memory.
module imem_port_arbiter #(
  parameter int          DEPTH     = 512,
  parameter int          IDX_W     = $clog2(DEPTH),
  parameter int          BURST_MAX = 8,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input logic               clk,
  input logic               rst,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OWN_IDLE, OWN_FETCH, OWN_LOAD} owner_t;

  localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

  owner_t      r_owner;
  owner_t      w_owner_nxt;
  logic [7:0]  r_burst_cnt;
  logic        r_resp_nop;
  logic [31:0] r_instr_hold;
  logic        r_misalign;

  logic        w_ld_gnt;
  logic        w_fetch_gnt;
  logic        w_resp_pend;
  logic        w_fetch_valid;
  logic [31:0] w_fetch_instr;
  logic        w_fetch_nop_out;
  logic        w_mem_en;
  logic        w_mem_we;
  logic [IDX_W-1:0] w_mem_idx;
  logic [31:0] w_mem_wdata;
  logic        w_access_misaligned;

  // Address bits above the word index wrap and are intentionally dropped.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{bus.fetch_addr[31:IDX_W+2], bus.ld_addr[31:IDX_W+2]};

  // The loader wins unless a fetch is waiting and the burst budget is spent.
  // Both grants are forced low while reset is held.
  assign w_ld_gnt    = rst && bus.ld_req && (!bus.fetch_req || (r_burst_cnt < BURST_MAX_C));
  assign w_fetch_gnt = rst && bus.fetch_req && !w_ld_gnt;

  // A fetch granted last cycle means its response is due now.
  assign w_resp_pend = (r_owner == OWN_FETCH);

  // Owner register: records which requester held the port in the last cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update from the same pre-edge values.
    if (!rst) r_owner <= OWN_IDLE;
    else      r_owner <= w_owner_nxt;
  end

  // Next owner: follows this cycle's grant.
  always_comb begin
    // NOTE: defaulting every combinational output first prevents latches.
    w_owner_nxt = OWN_IDLE;
    if (w_ld_gnt)         w_owner_nxt = OWN_LOAD;
    else if (w_fetch_gnt) w_owner_nxt = OWN_FETCH;
  end

  // Outputs: memory strobes for the current grant, and the response for last cycle's fetch.
  always_comb begin
    w_mem_en        = 1'b0;
    w_mem_we        = 1'b0;
    w_mem_idx       = bus.fetch_addr[IDX_W+1:2];
    w_mem_wdata     = '0;
    w_fetch_valid   = 1'b0;
    w_fetch_nop_out = 1'b0;
    w_fetch_instr   = r_instr_hold;
    if (w_ld_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = 1'b1;
      w_mem_idx   = bus.ld_addr[IDX_W+1:2];
      w_mem_wdata = bus.ld_wdata;
    end else if (w_fetch_gnt) begin
      w_mem_en = !bus.fetch_nop;
    end
    if (!rst) begin
      w_fetch_instr = NOP_WORD;
    end else if (w_resp_pend) begin
      w_fetch_valid   = 1'b1;
      w_fetch_nop_out = r_resp_nop;
      w_fetch_instr   = r_resp_nop ? NOP_WORD : bus.mem_rdata;
    end
  end

  assign w_access_misaligned = (w_ld_gnt    && (bus.ld_addr[1:0]    != 2'b00)) ||
                               (w_fetch_gnt && (bus.fetch_addr[1:0] != 2'b00));

  // Datapath state: burst budget, bubble tag, held instruction and sticky misalign flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_burst_cnt  <= '0;
      r_resp_nop   <= 1'b0;
      r_instr_hold <= NOP_WORD;
      r_misalign   <= 1'b0;
    end else begin
      if (w_fetch_gnt || !bus.ld_req)
        r_burst_cnt <= '0;
      else if (w_ld_gnt && bus.fetch_req && (r_burst_cnt != 8'hFF))
        r_burst_cnt <= r_burst_cnt + 8'd1;
      if (w_fetch_gnt) r_resp_nop <= bus.fetch_nop;
      if (w_fetch_valid) r_instr_hold <= w_fetch_instr;
      if (w_access_misaligned) r_misalign <= 1'b1;
    end
  end

  assign bus.ld_gnt        = w_ld_gnt;
  assign bus.fetch_gnt     = w_fetch_gnt;
  assign bus.fetch_valid   = w_fetch_valid;
  assign bus.fetch_instr   = w_fetch_instr;
  assign bus.fetch_nop_out = w_fetch_nop_out;
  assign bus.mem_en        = w_mem_en;
  assign bus.mem_we        = w_mem_we;
  assign bus.mem_idx       = w_mem_idx;
  assign bus.mem_wdata     = w_mem_wdata;
  assign bus.misalign      = r_misalign;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural synchronous-read memory.
module tb_imem_port_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  imem_port_arbiter_if #(.IDX_W(9)) bus ();

  imem_port_arbiter #(
    .DEPTH(512), .IDX_W(9), .BURST_MAX(8), .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory array. It only acts on the arbiter's strobes.
  logic [31:0] mem_model [512];
  initial for (int k = 0; k < 512; k++) mem_model[k] = 32'h1000_0000 + k;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_model[bus.mem_idx] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_model[bus.mem_idx];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.mem_rdata  = '0;
    rst            = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.ld_req     = 1'b1;
    bus.fetch_nop  = 1'b0;
    bus.fetch_addr = 32'h0;
    bus.ld_addr    = 32'h0;
    bus.ld_wdata   = 32'h0;

    // Reset held for three cycles with both requests asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
      check("rst_ld_gnt", 32'(bus.ld_gnt), 32'd0);
      check("rst_mem_en", 32'(bus.mem_en), 32'd0);
      check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      check("rst_fetch_instr", bus.fetch_instr, NOP);
    end

    @(negedge clk);
    rst = 1'b1; bus.fetch_req = 1'b0; bus.ld_req = 1'b0;
    #1;
    check("post_rst_valid", 32'(bus.fetch_valid), 32'd0);
    check("post_rst_misalign", 32'(bus.misalign), 32'd0);

    // Streaming fetch of words 0..3.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'(4 * k);
      #1;
      check("stream_gnt", 32'(bus.fetch_gnt), 32'd1);
      check("stream_mem_en", 32'(bus.mem_en), 32'd1);
      check("stream_mem_we", 32'(bus.mem_we), 32'd0);
      check("stream_idx", 32'(bus.mem_idx), 32'(k));
      if (k > 0) begin
        check("stream_valid", 32'(bus.fetch_valid), 32'd1);
        check("stream_instr", bus.fetch_instr, 32'h1000_0000 + 32'(k - 1));
      end
    end
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    check("stream_last_valid", 32'(bus.fetch_valid), 32'd1);
    check("stream_last_instr", bus.fetch_instr, 32'h1000_0003);
    check("stream_last_nop", 32'(bus.fetch_nop_out), 32'd0);
    @(negedge clk); #1;
    check("idle_valid", 32'(bus.fetch_valid), 32'd0);
    check("idle_hold", bus.fetch_instr, 32'h1000_0003);

    // Bubble request at 0x40.
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_nop = 1'b1; bus.fetch_addr = 32'h40;
    #1;
    check("bubble_gnt", 32'(bus.fetch_gnt), 32'd1);
    check("bubble_mem_en", 32'(bus.mem_en), 32'd0);
    @(negedge clk);
    bus.fetch_req = 1'b0; bus.fetch_nop = 1'b0;
    #1;
    check("bubble_valid", 32'(bus.fetch_valid), 32'd1);
    check("bubble_instr", bus.fetch_instr, NOP);
    check("bubble_nop_out", 32'(bus.fetch_nop_out), 32'd1);

    // Starvation bound: 8 loader grants then one fetch grant, repeating.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.ld_req = 1'b1; bus.fetch_req = 1'b1;
        bus.ld_addr = 32'h100; bus.ld_wdata = 32'hA5A5_0000; bus.fetch_addr = 32'h20;
      end
      #1;
      check("burst_ld_gnt", 32'(bus.ld_gnt), ((i % 9) != 8) ? 32'd1 : 32'd0);
      check("burst_fetch_gnt", 32'(bus.fetch_gnt), ((i % 9) == 8) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    bus.ld_req = 1'b0; bus.fetch_req = 1'b0;
    #1;
    check("burst_resp_valid", 32'(bus.fetch_valid), 32'd1);
    check("burst_resp_instr", bus.fetch_instr, 32'h1000_0008);

    // Loader write at the top word, then read it back, then wrap to index 0.
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_addr = 32'h7FC; bus.ld_wdata = 32'hDEAD_BEEF;
    #1;
    check("wr_ld_gnt", 32'(bus.ld_gnt), 32'd1);
    check("wr_mem_we", 32'(bus.mem_we), 32'd1);
    check("wr_idx", 32'(bus.mem_idx), 32'd511);
    check("wr_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("wr_no_valid", 32'(bus.fetch_valid), 32'd0);
    @(negedge clk);
    bus.ld_req = 1'b0; bus.fetch_req = 1'b1; bus.fetch_addr = 32'h7FC;
    #1;
    check("rd_top_idx", 32'(bus.mem_idx), 32'd511);
    @(negedge clk);
    bus.fetch_addr = 32'h800;
    #1;
    check("rd_wrap_idx", 32'(bus.mem_idx), 32'd0);
    check("rd_top_instr", bus.fetch_instr, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    check("rd_wrap_instr", bus.fetch_instr, 32'h1000_0000);

    // Fetch word 4, then the loader overwrites it while the old word returns.
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h10;
    #1;
    check("aligned_misalign", 32'(bus.misalign), 32'd0);
    @(negedge clk);
    bus.fetch_req = 1'b0; bus.ld_req = 1'b1; bus.ld_addr = 32'h10; bus.ld_wdata = 32'hCAFE_F00D;
    #1;
    check("raw_ld_gnt", 32'(bus.ld_gnt), 32'd1);
    check("raw_old_word", bus.fetch_instr, 32'h1000_0004);
    @(negedge clk);
    bus.ld_req = 1'b0; bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    check("raw_new_word", bus.fetch_instr, 32'hCAFE_F00D);

    // Misaligned fetch, then a stall.
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h06;
    #1;
    check("mis_idx", 32'(bus.mem_idx), 32'd1);
    check("mis_before", 32'(bus.misalign), 32'd0);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    check("mis_set", 32'(bus.misalign), 32'd1);
    check("mis_instr", bus.fetch_instr, 32'h1000_0001);
    @(negedge clk); #1;
    check("stall_valid", 32'(bus.fetch_valid), 32'd0);
    check("stall_hold", bus.fetch_instr, 32'h1000_0001);
    check("mis_sticky", 32'(bus.misalign), 32'd1);

    // Reset mid-access: the pending response is dropped and the loader write is blocked.
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
    @(negedge clk);
    rst = 1'b0; bus.fetch_req = 1'b0; bus.ld_req = 1'b1; bus.ld_addr = 32'h0; bus.ld_wdata = 32'hBAD0_BAD0;
    #1;
    check("mid_rst_valid", 32'(bus.fetch_valid), 32'd0);
    check("mid_rst_ld_gnt", 32'(bus.ld_gnt), 32'd0);
    check("mid_rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("mid_rst_instr", bus.fetch_instr, NOP);
    @(negedge clk);
    rst = 1'b1; bus.ld_req = 1'b0;
    #1;
    check("after_rst_valid", 32'(bus.fetch_valid), 32'd0);
    check("after_rst_misalign", 32'(bus.misalign), 32'd0);
    check("after_rst_hold", bus.fetch_instr, NOP);
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    check("rst_write_blocked", bus.fetch_instr, 32'h1000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
